shift_add_multiplier: RTL

//   Sequential unsigned N x N -> 2N multiplier, radix-2 shift-and-add, one partial product per clock.
//   It is the control/datapath stage that feeds the team's combinational N_bit_adder and consumes its result.
//   The adder's ports are input1, input2, carry_in, answer and carry_out.

---
 rtl/shift_add_multiplier_pkg.sv | 14 +
 rtl/shift_add_multiplier_adder.sv | 22 ++
 rtl/shift_add_multiplier.sv | 108 ++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the default operand width.
package shift_add_multiplier_pkg;

    localparam int DEFAULT_N = 16;

    // Two-bit state encoding; the fourth code is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : shift_add_multiplier_pkg

// File: rtl/shift_add_multiplier_adder.sv
// Combinational N-bit ripple adder with carry in/out. The multiplier uses it
// to add the selected multiplicand into the running partial product.
module N_bit_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    input  logic         carry_in,
    output logic [N-1:0] answer,
    output logic         carry_out
);

    localparam int W = N + 1;

    logic [N:0] full_sum;

    // Widen both operands by one bit so the carry out is kept, not truncated.
    assign full_sum  = {1'b0, input1} + {1'b0, input2} + W'(carry_in);
    assign answer    = full_sum[N-1:0];
    assign carry_out = full_sum[N];

endmodule : N_bit_adder

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N multiplier. One partial product is added
// and shifted per clock; operands and product move over valid/ready
// handshakes. The running product lives in {P,Q}: P is the upper half, Q
// starts as the multiplier and is shifted out one bit per cycle.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    state_e        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  p_q, p_d;
    logic [N-1:0]  q_q, q_d;
    logic [CW-1:0] count_q, count_d;

    logic [N-1:0]  addend;
    logic [N-1:0]  sum;
    logic          carry;
    logic [2*N:0]  shifted;

    // The multiplicand is added only when the current multiplier bit is set.
    assign addend = q_q[0] ? a_q : '0;

    N_bit_adder #(.N(N)) u_adder (
        .input1    (p_q),
        .input2    (addend),
        .carry_in  (1'b0),
        .answer    (sum),
        .carry_out (carry)
    );

    // Carry lands in the top bit of P; the low sum bit moves into Q.
    assign shifted = {carry, sum, q_q} >> 1;

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            p_q     <= p_d;
            q_q     <= q_d;
            count_q <= count_d;
        end
    end

    // Next-state and datapath update: accept, iterate N times, hold until drained.
    always_comb begin
        // NOTE: hold values are assigned first so no path leaves a signal unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        p_d     = p_q;
        q_d     = q_q;
        count_d = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = multiplicand;
                    q_d     = multiplier;
                    p_d     = '0;
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                p_d     = shifted[2*N-1:N];
                q_d     = shifted[N-1:0];
                count_d = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake flags decode directly from the registered state.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign product   = {p_q, q_q};

endmodule : shift_add_multiplier
